rr_pipe_arbiter: RTL and testbench
==================================

RR_PIPE_ARBITER -- requirements
Module: rr_pipe_arbiter

Interface
REQ-001 Parameter data_width, default 8, width of each requester's data word.
REQ-002 Parameter num_req, default 4, number of requesters; legal range 2..8.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port in_valid  input  num_req  per-requester valid; bit i belongs to requester i.
REQ-006 Port in_data  input  num_req*data_width  packed data; requester i occupies bits [i*data_width +: data_width].
REQ-007 Port in_ready  output  num_req  per-requester ready; bit i high means requester i's word is accepted this cycle.
REQ-008 Port out_valid  output  1  held word valid toward downstream pipeline stage.
REQ-009 Port out_data  output  data_width  held word.
REQ-010 Port out_id  output  clog2(num_req)  index of requester that supplied the held word.
REQ-011 Port out_ready  input  1  downstream ready.
REQ-012 Port xfer_count  output  16  count of words accepted from requesters since reset.

Function
REQ-013 Block SHALL contain one output register (out_valid/out_data/out_id) and a round-robin pointer rr_ptr of clog2(num_req) bits.
REQ-014 can_load = ~out_valid | out_ready, combinational.
REQ-015 grant SHALL select the first i with in_valid[i]=1 scanning rr_ptr, rr_ptr+1, ... modulo num_req; no grant if in_valid is all zero.
REQ-016 in_ready[i] = can_load & grant[i]; at most one in_ready bit high per cycle; all zero when can_load=0.
REQ-017 Transfer from requester i occurs when in_valid[i] & in_ready[i] at a rising edge.
REQ-018 On transfer: out_data <= word i, out_id <= i, out_valid <= 1, rr_ptr <= (i+1) mod num_req, xfer_count <= xfer_count+1.
REQ-019 No transfer and out_valid & out_ready: out_valid <= 0; out_data/out_id hold last value.
REQ-020 No transfer and out_valid & ~out_ready: out_valid, out_data, out_id SHALL remain stable (stall).
REQ-021 Simultaneous drain and load (out_valid & out_ready & transfer): new word replaces old in the same edge; sustained throughput one word per cycle.
REQ-022 Latency: a word accepted at edge N is presented on out_* during cycle N+1.
REQ-023 rr_ptr SHALL change only on a transfer; idle or stalled cycles leave it unchanged.
REQ-024 Single active requester SHALL be granted every cycle while can_load=1 (no forced gaps).
REQ-025 Fairness: with all requesters continuously valid and out_ready=1, grants rotate 0,1,...,num_req-1,0,...; each requester waits at most num_req-1 transfers.
REQ-026 xfer_count SHALL wrap 0xFFFF -> 0x0000 without affecting other state.
REQ-027 Requester dropping in_valid while not granted SHALL have no effect on state.

Reset
REQ-028 While rst_n=0 at a rising edge: out_valid=0, out_data=0, out_id=0, rr_ptr=0, xfer_count=0.
REQ-029 Reset mid-operation SHALL discard any held word; in_ready SHALL be all zero only through can_load/grant rules (out_valid=0 after reset so first requester is grantable next cycle).
REQ-030 Reset has priority over any simultaneous transfer.

Verification
REQ-031 Reset, then in_valid=4'b0001, in_data[0]=8'hA5, out_ready=1 -> in_ready=4'b0001 one edge; next cycle out_valid=1, out_data=8'hA5, out_id=0, xfer_count=1.
REQ-032 All four valid (data 8'h10,8'h21,8'h32,8'h43), out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3, one word per cycle, xfer_count=8.
REQ-033 Held word 8'h21, out_ready=0 for 3 cycles with all requesters valid -> in_ready=0, out_data=8'h21 and rr_ptr stable; out_ready=1 -> next grant is requester 2.
REQ-034 rr_ptr=3, only requester 1 valid -> requester 1 granted immediately; rr_ptr becomes 2.
REQ-035 Preload xfer_count to 0xFFFF via 65535 transfers, one more transfer -> xfer_count=0x0000, data path unaffected.
REQ-036 Assert rst_n=0 for one edge while out_valid=1 and requester 2 valid -> after edge out_valid=0, xfer_count=0, rr_ptr=0; requester 0 granted first when rst_n=1 and all valid.

Source files
------------

// File: rtl/rr_pipe_arbiter.sv
// Round-robin N:1 arbiter feeding a single registered output stage.
// A requester is accepted when it holds the grant and the output slot is free or draining.
module rr_pipe_arbiter #(
  parameter int unsigned data_width = 8,
  parameter int unsigned num_req    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [num_req-1:0]              in_valid,
  input  logic [num_req*data_width-1:0]   in_data,
  output logic [num_req-1:0]              in_ready,
  output logic                            out_valid,
  output logic [data_width-1:0]           out_data,
  output logic [$clog2(num_req)-1:0]      out_id,
  input  logic                            out_ready,
  output logic [15:0]                     xfer_count
);

  localparam int unsigned IdW = $clog2(num_req);

  logic                  out_valid_q, out_valid_d;
  logic [data_width-1:0] out_data_q, out_data_d;
  logic [IdW-1:0]        out_id_q, out_id_d;
  logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [15:0]           count_q, count_d;

  logic                  can_load;
  logic                  found;
  logic                  xfer;
  logic [IdW-1:0]        idx;
  logic [IdW-1:0]        grant_id;
  logic [num_req-1:0]    grant;
  logic [data_width-1:0] grant_word;

  assign can_load = ~out_valid_q | out_ready;

  // Scan requesters starting at rr_ptr, wrapping modulo num_req; first valid one wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < num_req; k++) begin
      idx = IdW'((32'(rr_ptr_q) + k) % num_req);
      if (!found && in_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    grant_word = '0;
    for (int unsigned i = 0; i < num_req; i++) begin
      if (grant[i]) begin
        grant_word = in_data[i*data_width +: data_width];
      end
    end
  end

  assign in_ready = can_load ? grant : '0;
  assign xfer     = |in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    count_d     = count_q;
    if (xfer) begin
      // A load also covers the simultaneous drain of the previous word.
      out_valid_d = 1'b1;
      out_data_d  = grant_word;
      out_id_d    = grant_id;
      rr_ptr_d    = (grant_id == IdW'(num_req - 1)) ? '0 : grant_id + 1'b1;
      count_d     = count_q + 16'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_rr_pipe_arbiter.sv
// Self-checking bench for rr_pipe_arbiter (4 requesters, 8-bit data).
// Accepted words are queued when granted and checked while held and when consumed.
module tb_rr_pipe_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ready;
  logic [15:0] xfer_count;

  rr_pipe_arbiter #(
    .data_width(8),
    .num_req   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0] v;
    logic       rdy;
    logic [3:0] exp_rdy;
    string      name;
  } vec_t;

  exp_t        sb[$];
  logic        m_ov;
  logic [15:0] m_count;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] v, input logic rdy);
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = v;
    out_ready = rdy;
    @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst out_id", 32'(out_id), 32'd0);
    chk("rst xfer_count", 32'(xfer_count), 32'd0);
    sb.delete();
    m_ov    = 1'b0;
    m_count = '0;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = '0;
  endtask

  task automatic cycle(input logic [3:0] v, input logic rdy, input logic [3:0] erdy,
                       input string name);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    out_ready = rdy;
    #1;
    chk({name, " in_ready"}, 32'(in_ready), 32'(erdy));
    if (m_ov && rdy) begin
      if (sb.size() == 0) begin
        chk({name, " sb_underflow"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk({name, " consumed"}, {22'd0, out_id, out_data}, {22'd0, e.id, e.data});
      end
    end
    if (erdy != 4'd0) begin
      for (int i = 0; i < 4; i++) begin
        if (erdy[i]) begin
          e.id   = 2'(i);
          e.data = in_data[i*8 +: 8];
        end
      end
      sb.push_back(e);
      m_count++;
      m_ov = 1'b1;
    end else if (rdy) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({name, " out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({name, " xfer_count"}, 32'(xfer_count), 32'(m_count));
    if (m_ov && sb.size() > 0) begin
      chk({name, " held"}, {22'd0, out_id, out_data}, {22'd0, sb[0].id, sb[0].data});
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{4'b1111, 1'b1, 4'b0001, "rot0"};
    tbl[1] = '{4'b1111, 1'b1, 4'b0010, "rot1"};
    tbl[2] = '{4'b1111, 1'b1, 4'b0100, "rot2"};
    tbl[3] = '{4'b1111, 1'b1, 4'b1000, "rot3"};
    tbl[4] = '{4'b1111, 1'b1, 4'b0001, "rot4"};
    tbl[5] = '{4'b1111, 1'b1, 4'b0010, "rot5"};
    tbl[6] = '{4'b1111, 1'b1, 4'b0100, "rot6"};
    tbl[7] = '{4'b1111, 1'b1, 4'b1000, "rot7"};

    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    m_ov      = 1'b0;
    m_count   = '0;

    // Single word through the pipe.
    in_data = 32'h000000A5;
    do_reset(4'b0000, 1'b1);
    cycle(4'b0001, 1'b1, 4'b0001, "single");
    cycle(4'b0000, 1'b1, 4'b0000, "single_drain");

    // Full rotation, one word per cycle.
    in_data = 32'h43322110;
    do_reset(4'b0000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].v, tbl[i].rdy, tbl[i].exp_rdy, tbl[i].name);
    end
    chk("rot count", 32'(xfer_count), 32'd8);
    cycle(4'b0000, 1'b1, 4'b0000, "rot_drain");

    // Stall holds word and pointer.
    do_reset(4'b0000, 1'b1);
    cycle(4'b1111, 1'b1, 4'b0001, "st_load0");
    cycle(4'b1111, 1'b1, 4'b0010, "st_load1");
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b0, 4'b0000, "stall");
      chk("stall data", 32'(out_data), 32'h21);
    end
    cycle(4'b1111, 1'b1, 4'b0100, "st_resume");
    cycle(4'b0000, 1'b0, 4'b0000, "st_idle_hold");
    cycle(4'b0000, 1'b1, 4'b0000, "st_drain");
    cycle(4'b0000, 1'b1, 4'b0000, "st_empty");

    // Pointer at 3, only requester 1 valid; lone requester granted every cycle.
    do_reset(4'b0000, 1'b1);
    cycle(4'b0100, 1'b1, 4'b0100, "p_set3");
    cycle(4'b0010, 1'b1, 4'b0010, "p_wrap1");
    cycle(4'b0010, 1'b1, 4'b0010, "p_lone");
    cycle(4'b1111, 1'b1, 4'b0100, "p_next2");
    cycle(4'b1000, 1'b0, 4'b0000, "p_stall_drop");
    cycle(4'b0001, 1'b1, 4'b0001, "p_after_drop");
    cycle(4'b0000, 1'b1, 4'b0000, "p_drain");

    // Reset wins over a simultaneous transfer.
    do_reset(4'b0000, 1'b1);
    cycle(4'b1111, 1'b1, 4'b0001, "r_load");
    cycle(4'b1111, 1'b1, 4'b0010, "r_load2");
    do_reset(4'b0100, 1'b1);
    cycle(4'b1111, 1'b1, 4'b0001, "r_first0");
    cycle(4'b0000, 1'b1, 4'b0000, "r_drain");

    // Counter wrap after 65535 back-to-back transfers.
    do_reset(4'b0000, 1'b1);
    @(negedge clk);
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap pre", 32'(xfer_count), 32'hFFFF);
    m_count = 16'hFFFF;
    m_ov    = 1'b1;
    sb.push_back('{2'd0, 8'h10});
    in_data = 32'h4332215A;
    cycle(4'b0001, 1'b1, 4'b0001, "wrap");
    chk("wrap zero", 32'(xfer_count), 32'h0);
    cycle(4'b0000, 1'b1, 4'b0000, "wrap_drain");
    chk("sb empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
